// File: rtl/l0_pkg.sv
// Shared definitions for the L0 input buffer: FIFO geometry, default row count
// and the read-sequencer FSM encoding.
package l0_pkg;

  localparam int L0_DEPTH = 64;
  localparam int L0_PTR_W = 7;
  localparam int ROW      = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } l0_state_e;

  // Bursts longer than one FIFO's depth are capped at the depth.
  function automatic logic [L0_PTR_W-1:0] clamp_len(input logic [31:0] l);
    logic [L0_PTR_W-1:0] r;
    if (l > 32'(L0_DEPTH)) begin
      r = L0_PTR_W'(L0_DEPTH);
    end else begin
      r = L0_PTR_W'(l);
    end
    return r;
  endfunction

endpackage

// File: rtl/l0_rd_sequencer.sv
// Drains one burst of len vectors from every L0 row FIFO, either diagonally
// skewed or in parallel, freezing the whole wavefront while a due row is empty.
module l0_rd_sequencer
  import l0_pkg::*;
#(
  parameter int row   = ROW,
  parameter int len_w = 7,
  parameter int cnt_w = 16
) (
  input  logic             rd_clk,
  input  logic             reset,
  input  logic             start,
  input  logic [len_w-1:0] len,
  input  logic             skew_en,
  input  logic [row-1:0]   row_empty,
  output logic [row-1:0]   rd_row,
  output logic             busy,
  output logic             done,
  output logic [cnt_w-1:0] stall_cnt
);

  l0_state_e             state_r, state_s;
  logic [row-1:0]        pend_r, pend_s;
  logic [L0_PTR_W-1:0]   cnt_r, cnt_s, cnt_plus_s;
  logic [L0_PTR_W-1:0]   len_q_r, len_q_s;
  logic                  skew_q_r, skew_q_s;
  logic                  stall_s, nh_s;
  logic                  busy_r, done_r;
  logic [cnt_w-1:0]      stall_cnt_r;

  // Stall gating stays combinational so an empty FIFO is never strobed.
  always_comb begin
    stall_s = |(pend_r & row_empty);
    if (stall_s) begin
      rd_row = {row{1'b0}};
    end else begin
      rd_row = pend_r;
    end
  end

  // Next-state, wavefront shift and issue-count logic.
  always_comb begin
    state_s    = state_r;
    pend_s     = pend_r;
    cnt_s      = cnt_r;
    len_q_s    = len_q_r;
    skew_q_s   = skew_q_r;
    cnt_plus_s = cnt_r + {{(L0_PTR_W-1){1'b0}}, 1'b1};
    nh_s       = pend_r[0] && (cnt_plus_s < len_q_r);
    case (state_r)
      IDLE: begin
        if (start) begin
          len_q_s  = clamp_len(32'(len));
          skew_q_s = skew_en;
          cnt_s    = {L0_PTR_W{1'b0}};
          if (len == {len_w{1'b0}}) begin
            state_s = DONE;
            pend_s  = {row{1'b0}};
          end else begin
            state_s = RUN;
            if (skew_en) begin
              pend_s = {{(row-1){1'b0}}, 1'b1};
            end else begin
              pend_s = {row{1'b1}};
            end
          end
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (!stall_s) begin
          if (pend_r[0]) begin
            cnt_s = cnt_plus_s;
          end else begin
            cnt_s = cnt_r;
          end
          if (skew_q_r) begin
            pend_s = {pend_r[row-2:0], nh_s};
          end else begin
            pend_s = {row{nh_s}};
          end
          if (pend_s == {row{1'b0}}) begin
            state_s = DONE;
          end else begin
            state_s = RUN;
          end
        end else begin
          state_s = RUN;
        end
      end
      DONE: begin
        state_s = IDLE;
        pend_s  = {row{1'b0}};
      end
      default: begin
        state_s = IDLE;
        pend_s  = {row{1'b0}};
      end
    endcase
  end

  // Sequencer state registers; busy/done are registered decodes of next state.
  always_ff @(posedge rd_clk or posedge reset) begin
    if (reset) begin
      state_r  <= IDLE;
      pend_r   <= {row{1'b0}};
      cnt_r    <= {L0_PTR_W{1'b0}};
      len_q_r  <= {L0_PTR_W{1'b0}};
      skew_q_r <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      state_r  <= state_s;
      pend_r   <= pend_s;
      cnt_r    <= cnt_s;
      len_q_r  <= len_q_s;
      skew_q_r <= skew_q_s;
      busy_r   <= (state_s != IDLE);
      done_r   <= (state_s == DONE);
    end
  end

  // Saturating count of cycles the wavefront was frozen.
  always_ff @(posedge rd_clk or posedge reset) begin
    if (reset) begin
      stall_cnt_r <= {cnt_w{1'b0}};
    end else if (state_r == RUN && stall_s && stall_cnt_r != {cnt_w{1'b1}}) begin
      stall_cnt_r <= stall_cnt_r + {{(cnt_w-1){1'b0}}, 1'b1};
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign busy      = busy_r;
  assign done      = done_r;
  assign stall_cnt = stall_cnt_r;

endmodule

// File: tb/tb_l0_rd_sequencer.sv
// Self-checking bench for l0_rd_sequencer: table of bursts checked cycle by
// cycle against a timing model, with a scoreboard of per-burst results.
module tb_l0_rd_sequencer;

  logic        rd_clk;
  logic        reset;
  logic        start;
  logic [6:0]  len;
  logic        skew_en;
  logic [7:0]  row_empty;
  logic [7:0]  rd_row;
  logic        busy;
  logic        done;
  logic [15:0] stall_cnt;

  l0_rd_sequencer #(.row(8), .len_w(7), .cnt_w(16)) dut (
    .rd_clk(rd_clk), .reset(reset), .start(start), .len(len), .skew_en(skew_en),
    .row_empty(row_empty), .rd_row(rd_row), .busy(busy), .done(done),
    .stall_cnt(stall_cnt)
  );

  initial rd_clk = 1'b0;
  always #5 rd_clk = ~rd_clk;

  typedef struct {
    int len; int skew; int e_row; int e_start; int e_len; int busy_k;
    int exp_done; int exp_strobes; int exp_stalls;
  } vec_t;

  typedef struct { int done_k; int strobes; int stall_total; } sb_t;

  vec_t vecs[8];
  sb_t  sb_q[$];
  int   n_pass = 0;
  int   n_tot  = 0;
  int   exp_stall_total = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic run_burst(input vec_t v);
    int k, stalls, lq, deff, eff;
    int cnt_str[8];
    logic [7:0] due, exp_rd, emp;
    bit st, got_done;
    sb_t s;
    lq = (v.len > 64) ? 64 : v.len;
    deff = (lq == 0) ? 1 : ((v.skew != 0) ? lq + 8 : lq + 1);
    exp_stall_total += v.exp_stalls;
    s.done_k = v.exp_done; s.strobes = v.exp_strobes; s.stall_total = exp_stall_total;
    sb_q.push_back(s);
    for (int i = 0; i < 8; i++) cnt_str[i] = 0;
    start = 1'b1; len = 7'(v.len); skew_en = (v.skew != 0); row_empty = 8'd0;
    @(negedge rd_clk);
    start = 1'b0;
    k = 1; stalls = 0; got_done = 1'b0;
    while (!got_done && k <= 150) begin
      emp = (v.e_len > 0 && k >= v.e_start && k < v.e_start + v.e_len) ? (8'd1 << v.e_row) : 8'd0;
      row_empty = emp;
      start = (k == v.busy_k);
      if (start) len = 7'd10;
      #1;
      eff = k - stalls;
      due = 8'd0;
      for (int i = 0; i < 8; i++) begin
        if (lq > 0 && ((v.skew != 0) ? (eff >= 1 + i && eff <= i + lq) : (eff >= 1 && eff <= lq)))
          due[i] = 1'b1;
      end
      st = |(due & emp);
      exp_rd = st ? 8'd0 : due;
      if (st) stalls++;
      check("rd_row", 64'(rd_row), 64'(exp_rd));
      check("done", 64'(done), 64'(eff == deff));
      check("busy", 64'(busy), 64'(eff <= deff));
      for (int i = 0; i < 8; i++) if (rd_row[i] === 1'b1) cnt_str[i]++;
      if (done === 1'b1) begin
        got_done = 1'b1;
        s = sb_q.pop_front();
        check("done_cycle", 64'(k), 64'(s.done_k));
        for (int i = 0; i < 8; i++) check("strobes_per_row", 64'(cnt_str[i]), 64'(s.strobes));
        check("stall_cnt", 64'(stall_cnt), 64'(s.stall_total));
      end
      @(negedge rd_clk);
      k++;
    end
    start = 1'b0; row_empty = 8'd0;
    if (!got_done) begin
      check("done_timeout", 64'(0), 64'(1));
      if (sb_q.size() > 0) s = sb_q.pop_front();
    end
    #1;
    check("idle_busy", 64'(busy), 64'(0));
    check("idle_done", 64'(done), 64'(0));
  endtask

  initial begin
    //          len  skew e_row e_st e_len busy_k done strobes stalls
    vecs[0] = '{4,   1,   0,    0,   0,    0,     12,  4,      0};
    vecs[1] = '{64,  0,   0,    0,   0,    0,     65,  64,     0};
    vecs[2] = '{4,   1,   3,    5,   5,    0,     17,  4,      5};
    vecs[3] = '{0,   1,   0,    0,   0,    0,     1,   0,      0};
    vecs[4] = '{100, 1,   0,    0,   0,    0,     72,  64,     0};
    vecs[5] = '{3,   0,   0,    2,   2,    0,     6,   3,      2};
    vecs[6] = '{5,   1,   0,    0,   0,    3,     13,  5,      0};
    vecs[7] = '{4,   1,   7,    1,   3,    0,     12,  4,      0};

    reset = 1'b1; start = 1'b0; len = 7'd0; skew_en = 1'b0; row_empty = 8'd0;
    repeat (2) @(negedge rd_clk);
    check("reset_rd_row", 64'(rd_row), 64'(0));
    check("reset_busy", 64'(busy), 64'(0));
    check("reset_done", 64'(done), 64'(0));
    check("reset_stall_cnt", 64'(stall_cnt), 64'(0));
    reset = 1'b0;
    @(negedge rd_clk);

    for (int n = 0; n < 8; n++) run_burst(vecs[n]);

    // Asynchronous reset in the middle of a skewed burst.
    start = 1'b1; len = 7'd8; skew_en = 1'b1;
    @(negedge rd_clk);
    start = 1'b0;
    repeat (2) @(negedge rd_clk);
    #2;
    check("mid_run_rd_row", 64'(rd_row), 64'(8'b0000_0111));
    reset = 1'b1;
    #1;
    check("async_rst_rd_row", 64'(rd_row), 64'(0));
    check("async_rst_busy", 64'(busy), 64'(0));
    check("async_rst_done", 64'(done), 64'(0));
    check("async_rst_stall_cnt", 64'(stall_cnt), 64'(0));
    @(negedge rd_clk);
    reset = 1'b0;
    exp_stall_total = 0;
    @(negedge rd_clk);
    run_burst('{2, 1, 0, 0, 0, 0, 10, 2, 0});

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
